// File: rtl/operand_select_pipe.sv
// Registered N-way operand-B selector feeding a depth-2 skid buffer.
// Out-of-range selects yield zero, are flagged per entry and counted.
module operand_select_pipe #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              err_count
);

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } occ_t;

   occ_t             state;
   logic [WIDTH-1:0] skid_data;
   logic             skid_err;
   logic [WIDTH-1:0] sel_val;
   logic             sel_err;
   logic             accept;
   logic             pop;

   // Compare against each legal index so an out-of-range sel never indexes.
   always_comb begin
      sel_val = '0;
      sel_err = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            sel_val = in_data[k*WIDTH +: WIDTH];
            sel_err = 1'b0;
         end
      end
   end

   assign accept = in_valid & in_ready & ~rst;
   assign pop    = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
         skid_data <= '0;
         skid_err  <= 1'b0;
         in_ready  <= 1'b0;
         err_count <= '0;
      end else begin
         if (accept && sel_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
         unique case (state)
            EMPTY: begin
               in_ready <= 1'b1;
               if (accept) begin
                  out_data  <= sel_val;
                  out_err   <= sel_err;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               in_ready <= 1'b1;
               unique case ({accept, pop})
                  2'b11: begin
                     out_data <= sel_val;
                     out_err  <= sel_err;
                  end
                  2'b10: begin
                     skid_data <= sel_val;
                     skid_err  <= sel_err;
                     in_ready  <= 1'b0;
                     state     <= TWO;
                  end
                  2'b01: begin
                     out_valid <= 1'b0;
                     state     <= EMPTY;
                  end
                  default: ;
               endcase
            end
            TWO: begin
               in_ready <= 1'b0;
               if (pop) begin
                  out_data <= skid_data;
                  out_err  <= skid_err;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
               state     <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: doc/operand_select_pipe.md
# operand_select_pipe

Parametrised, registered N-way operand selector for the datapath's ALU operand-B path, generalising the 1-bit 2:1 operand mux to WIDTH-bit operands and NUM_IN sources. The selection is captured into a two-entry skid buffer with valid/ready handshakes on both sides, so operand selection can be pipelined without throughput loss under downstream backpressure. Out-of-range selects are flagged per operand and counted.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (>=1)
- NUM_IN, 4, number of source operands (>=2)
- SEL_W, $clog2(NUM_IN), select width (derived; not overridden)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  NUM_IN*WIDTH  source operands flattened; source k at bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  source index, sampled with in_data on acceptance
- in_valid  input  1  upstream offers {in_data, sel}
- in_ready  output  1  block can accept this cycle; registered
- out_data  output  WIDTH  selected operand (head entry)
- out_err  output  1  head entry had sel >= NUM_IN
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream consumes head this cycle
- err_count  output  8  saturating count of accepted out-of-range selects

## Operation
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- On accept: value = (sel < NUM_IN) ? source[sel] : 0; err = (sel >= NUM_IN). Value and err stored as one entry.
- Storage: head register (drives out_*) and skid register. States by occupancy:
  - EMPTY (head invalid, skid invalid): accept -> entry to head, go ONE.
  - ONE (head valid): accept & pop -> new entry to head, stay ONE; accept & !pop -> entry to skid, go TWO; pop & !accept -> EMPTY; neither -> hold.
  - TWO (both valid): in_ready = 0, no accept; pop -> skid moves to head, go ONE; no pop -> hold.
- in_ready = !skid_valid, registered (next-state of skid valid); never depends combinationally on out_ready.
- Order is strictly preserved (FIFO, depth 2).
- err_count increments by 1 on each accept with err = 1; saturates at 255; cleared only by reset.
- Head/skid contents hold unchanged while not written; out_data/out_err stable while out_valid & !out_ready.
- Accept in EMPTY with simultaneous out_ready: entry appears on out_* next cycle (no same-cycle passthrough).

## Timing
- Latency: accepted entry visible on out_data/out_valid exactly 1 cycle after accept edge (from EMPTY or via ONE with pop).
- Throughput: 1 entry/cycle sustained while out_ready = 1.
- Backpressure: with out_ready = 0, accepts at most 2 entries; in_ready falls the cycle after the second accept.
- Release: in_ready rises the cycle after the pop that empties skid.
- Reset (rst = 1 at an edge): out_valid = 0, out_data = 0, out_err = 0, err_count = 0, skid cleared, in_ready = 0 while rst is held; in_ready = 1 on the first cycle after rst deasserts. Reset mid-transfer discards all stored entries; no entry emitted after reset until a new accept.
- in_valid/in_data/sel ignored while in_ready = 0 or rst = 1.

## Test plan
- Reset: hold rst 3 cycles with in_valid = 1 -> out_valid = 0, out_data = 0, err_count = 0, in_ready = 0; cycle after release in_ready = 1.
- Streaming: WIDTH=8, NUM_IN=4, sources {0x11,0x22,0x33,0x44}, sel = 0,1,2,3 on consecutive cycles, out_ready = 1 -> out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after first accept, in_ready stays 1.
- Backpressure: out_ready = 0, offer sel = 2 then sel = 3 -> both accepted, in_ready = 0 next cycle, out_data = 0x33 held; raise out_ready -> 0x33 then 0x44, in_ready returns 1 cycle after skid drains.
- Out-of-range: NUM_IN = 3, sel = 3 accepted -> out_data = 0, out_err = 1, err_count = 1; 300 such accepts -> err_count = 255.
- Simultaneous accept+pop in ONE: head 0x22 valid, out_ready = 1, accept sel = 0 -> next cycle out_data = 0x11, skid empty, in_ready = 1.
- Reset mid-operation: state TWO, assert rst one cycle -> out_valid = 0, both entries lost, in_ready = 1 after release, next accept emerges with 1-cycle latency.
